// File: rtl/bp_lce_req_queue.sv
// Multi-entry LCE request handler: buffers cache requests, attaches in-order metadata and
// issues BedRock LCE request messages from the head entry, bounded by a credit counter.
module bp_lce_req_queue
  #(parameter int paddr_width_p    = 40
  , parameter int lce_id_width_p   = 4
  , parameter int cce_id_width_p   = 4
  , parameter int num_cce_p        = 4
  , parameter int lce_assoc_p      = 8
  , parameter int entries_p        = 4
  , parameter int credits_p        = 8
  , parameter int block_width_p    = 512
  , parameter bit non_excl_reads_p = 1'b0
  , localparam int way_width_lp               = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1
  , localparam int cache_req_width_lp         = 4 + paddr_width_p + 3 + 64 + 1
  , localparam int cache_req_metadata_width_lp = way_width_lp
  , localparam int lce_req_msg_width_lp       = 4 + 4 + paddr_width_p + 3 + lce_id_width_p
                                                + cce_id_width_p + way_width_lp + 2 + 64
  )
  (input  logic                                   clk_i
  , input  logic                                  reset_i
  , input  logic [lce_id_width_p-1:0]             lce_id_i
  , input  logic [1:0]                            lce_mode_i
  , input  logic                                  sync_done_i
  , input  logic [cache_req_width_lp-1:0]         cache_req_i
  , input  logic                                  cache_req_v_i
  , output logic                                  cache_req_yumi_o
  , input  logic [cache_req_metadata_width_lp-1:0] cache_req_metadata_i
  , input  logic                                  cache_req_metadata_v_i
  , input  logic                                  cache_req_complete_i
  , input  logic                                  uc_req_complete_i
  , output logic                                  credits_full_o
  , output logic                                  credits_empty_o
  , output logic                                  empty_o
  , output logic [lce_req_msg_width_lp-1:0]       lce_req_o
  , output logic                                  lce_req_v_o
  , input  logic                                  lce_req_ready_i
  );

  localparam int ptr_w_lp        = (entries_p > 1) ? $clog2(entries_p) : 1;
  localparam int credit_width_lp = $clog2(credits_p + 1);
  localparam int blk_off_lp      = $clog2(block_width_p / 8);

  // lce_mode_i: 0 uncached, 1 normal, 2 nonspec
  localparam logic [1:0] e_mode_uncached = 2'd0;
  localparam logic [1:0] e_mode_normal   = 2'd1;

  // cache request types; 4..14 are AMOs, subop = type - 4
  localparam logic [3:0] e_miss_load  = 4'd0;
  localparam logic [3:0] e_miss_store = 4'd1;
  localparam logic [3:0] e_uc_load    = 4'd2;
  localparam logic [3:0] e_uc_store   = 4'd3;
  localparam logic [3:0] e_amo_first  = 4'd4;
  localparam logic [3:0] e_amo_last   = 4'd14;

  localparam logic [3:0] e_req_rd    = 4'd0;
  localparam logic [3:0] e_req_wr    = 4'd1;
  localparam logic [3:0] e_req_uc_rd = 4'd2;
  localparam logic [3:0] e_req_uc_wr = 4'd3;
  localparam logic [3:0] e_req_amo   = 4'd4;

  typedef struct packed {
    logic [3:0]               msg_type;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               size;
    logic [63:0]              data;
    logic                     no_return;
  } cache_req_s;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [3:0]                subop;
    logic [paddr_width_p-1:0]  addr;
    logic [2:0]                size;
    logic [lce_id_width_p-1:0] src_id;
    logic [cce_id_width_p-1:0] dst_id;
    logic [way_width_lp-1:0]   lru_way_id;
    logic                      non_exclusive;
    logic                      amo_no_return;
    logic [63:0]               data;
  } lce_req_msg_s;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_w_lp'(entries_p - 1)) ? '0 : p + 1'b1;
  endfunction

  cache_req_s                    req_mem [entries_p];
  logic [way_width_lp-1:0]       way_mem [entries_p];
  logic [entries_p-1:0]          valid_r, meta_ok_r;
  logic [ptr_w_lp-1:0]           head_r, tail_r, meta_idx;
  logic [credit_width_lp-1:0]    credit_r;

  cache_req_s   in_req, head_req;
  lce_req_msg_s msg;
  logic is_miss, is_uc, is_amo, needs_meta, permitted, full, send, completion;
  logic meta_found, meta_exist, meta_new;

  assign in_req     = cache_req_i;
  assign is_miss    = (in_req.msg_type == e_miss_load) | (in_req.msg_type == e_miss_store);
  assign is_uc      = (in_req.msg_type == e_uc_load) | (in_req.msg_type == e_uc_store);
  assign is_amo     = (in_req.msg_type >= e_amo_first) & (in_req.msg_type <= e_amo_last);
  assign needs_meta = is_miss | is_amo;
  assign permitted  = (is_miss & (lce_mode_i == e_mode_normal) & sync_done_i)
                    | ((is_uc | is_amo) & ((lce_mode_i == e_mode_uncached) | sync_done_i));

  // Entries are contiguous from head, so the slot at tail is occupied only when full.
  assign full            = valid_r[tail_r];
  assign empty_o         = ~valid_r[head_r];
  assign credits_full_o  = (credit_r == credit_width_lp'(credits_p));
  assign credits_empty_o = (credit_r == '0);
  assign send            = ~reset_i & valid_r[head_r] & meta_ok_r[head_r]
                         & ~credits_full_o & lce_req_ready_i;
  assign cache_req_yumi_o = ~reset_i & cache_req_v_i & (~full | send) & permitted;
  assign lce_req_v_o      = send;
  assign completion       = cache_req_complete_i | uc_req_complete_i;

  // Oldest buffered entry still waiting for its metadata, searched from head.
  always_comb begin
    logic [ptr_w_lp:0]   idx_wide;
    logic [ptr_w_lp-1:0] idx;
    meta_found = 1'b0;
    meta_idx   = '0;
    idx_wide   = '0;
    idx        = '0;
    for (int i = 0; i < entries_p; i++) begin
      idx_wide = {1'b0, head_r} + (ptr_w_lp + 1)'(i);
      if (idx_wide >= (ptr_w_lp + 1)'(entries_p))
        idx_wide = idx_wide - (ptr_w_lp + 1)'(entries_p);
      idx = idx_wide[ptr_w_lp-1:0];
      if (!meta_found && valid_r[idx] && !meta_ok_r[idx]) begin
        meta_found = 1'b1;
        meta_idx   = idx;
      end
    end
  end

  assign meta_exist = cache_req_metadata_v_i & meta_found;
  assign meta_new   = cache_req_metadata_v_i & ~meta_found & cache_req_yumi_o & needs_meta;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_r    <= '0;
      tail_r    <= '0;
      valid_r   <= '0;
      meta_ok_r <= '0;
      credit_r  <= '0;
    end else begin
      // Pop first so a same-cycle accept into the freed slot (full case) wins.
      if (send) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= ptr_inc(head_r);
      end
      if (cache_req_yumi_o) begin
        valid_r[tail_r]   <= 1'b1;
        meta_ok_r[tail_r] <= ~needs_meta | meta_new;
        tail_r            <= ptr_inc(tail_r);
      end
      if (meta_exist)
        meta_ok_r[meta_idx] <= 1'b1;
      if (send & ~completion)
        credit_r <= credit_r + 1'b1;
      else if (~send & completion & (credit_r != '0))
        credit_r <= credit_r - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (cache_req_yumi_o)
      req_mem[tail_r] <= in_req;
    if (meta_new)
      way_mem[tail_r] <= cache_req_metadata_i;
    if (meta_exist)
      way_mem[meta_idx] <= cache_req_metadata_i;
  end

  assign head_req = req_mem[head_r];

  always_comb begin
    msg = '0;
    if (valid_r[head_r]) begin
      msg.addr   = head_req.addr;
      msg.size   = head_req.size;
      msg.src_id = lce_id_i;
      msg.dst_id = cce_id_width_p'((head_req.addr >> blk_off_lp) & paddr_width_p'(num_cce_p - 1));
      case (head_req.msg_type)
        e_miss_load: begin
          msg.msg_type      = e_req_rd;
          msg.size          = 3'(blk_off_lp);
          msg.lru_way_id    = way_mem[head_r];
          msg.non_exclusive = non_excl_reads_p;
        end
        e_miss_store: begin
          msg.msg_type   = e_req_wr;
          msg.size       = 3'(blk_off_lp);
          msg.lru_way_id = way_mem[head_r];
        end
        e_uc_load:  msg.msg_type = e_req_uc_rd;
        e_uc_store: begin
          msg.msg_type = e_req_uc_wr;
          msg.data     = head_req.data;
        end
        default: begin
          msg.msg_type      = e_req_amo;
          msg.subop         = head_req.msg_type - e_amo_first;
          msg.data          = head_req.data;
          msg.amo_no_return = head_req.no_return;
          msg.lru_way_id    = way_mem[head_r];
        end
      endcase
    end
  end

  assign lce_req_o = msg;

  a_meta_dropped : assert property (@(posedge clk_i) disable iff (reset_i)
    cache_req_metadata_v_i |-> (meta_found | meta_new));
  a_double_complete : assert property (@(posedge clk_i) disable iff (reset_i)
    !(cache_req_complete_i & uc_req_complete_i));
  a_complete_underflow : assert property (@(posedge clk_i) disable iff (reset_i)
    completion |-> (credit_r != '0));

endmodule

// File: tb/tb_bp_lce_req_queue.sv
// Scoreboard bench for bp_lce_req_queue: expected messages queued on accept, compared on issue.
module tb_bp_lce_req_queue;

  localparam int REQ_W = 112;
  localparam int MSG_W = 128;
  localparam logic [3:0] LCE_ID = 4'h3;
  localparam bit NON_EXCL = 1'b0;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic [3:0]        lce_id_i;
  logic [1:0]        lce_mode_i;
  logic              sync_done_i;
  logic [REQ_W-1:0]  cache_req_i;
  logic              cache_req_v_i;
  logic              cache_req_yumi_o;
  logic [2:0]        cache_req_metadata_i;
  logic              cache_req_metadata_v_i;
  logic              cache_req_complete_i;
  logic              uc_req_complete_i;
  logic              credits_full_o;
  logic              credits_empty_o;
  logic              empty_o;
  logic [MSG_W-1:0]  lce_req_o;
  logic              lce_req_v_o;
  logic              lce_req_ready_i;

  bp_lce_req_queue #(.entries_p(4), .credits_p(2), .non_excl_reads_p(NON_EXCL)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .lce_id_i(lce_id_i), .lce_mode_i(lce_mode_i),
    .sync_done_i(sync_done_i), .cache_req_i(cache_req_i), .cache_req_v_i(cache_req_v_i),
    .cache_req_yumi_o(cache_req_yumi_o), .cache_req_metadata_i(cache_req_metadata_i),
    .cache_req_metadata_v_i(cache_req_metadata_v_i), .cache_req_complete_i(cache_req_complete_i),
    .uc_req_complete_i(uc_req_complete_i), .credits_full_o(credits_full_o),
    .credits_empty_o(credits_empty_o), .empty_o(empty_o), .lce_req_o(lce_req_o),
    .lce_req_v_o(lce_req_v_o), .lce_req_ready_i(lce_req_ready_i));

  always #5 clk_i = ~clk_i;

  logic [MSG_W-1:0] sb[$];
  int yumi_q[$];
  int send_q[$];
  int cyc, checks, errors;
  bit auto_cmp, sent_prev, last_yumi, last_v;
  logic [2:0] exp_way;

  function automatic logic [REQ_W-1:0] mk_req(input logic [3:0] t, input logic [39:0] a,
                                              input logic [2:0] s, input logic [63:0] d,
                                              input logic nr);
    return {t, a, s, d, nr};
  endfunction

  // Expected BedRock message for a request and the way its metadata will carry.
  function automatic logic [MSG_W-1:0] model(input logic [REQ_W-1:0] r, input logic [2:0] way);
    logic [3:0] t, mt, sub, dst;
    logic [39:0] a;
    logic [2:0] s, sz, w;
    logic [63:0] d, md;
    logic nr, ne, anr;
    t = r[111:108]; a = r[107:68]; s = r[67:65]; d = r[64:1]; nr = r[0];
    dst = 4'((a >> 6) % 40'd4);
    mt = 4'd0; sub = 4'd0; sz = s; w = 3'd0; ne = 1'b0; anr = 1'b0; md = 64'd0;
    case (t)
      4'd0: begin mt = 4'd0; sz = 3'd6; w = way; ne = NON_EXCL; end
      4'd1: begin mt = 4'd1; sz = 3'd6; w = way; end
      4'd2: mt = 4'd2;
      4'd3: begin mt = 4'd3; md = d; end
      default: begin mt = 4'd4; sub = t - 4'd4; md = d; anr = nr; w = way; end
    endcase
    return {mt, sub, a, sz, LCE_ID, dst, w, ne, anr, md};
  endfunction

  // One clock cycle: sample outputs mid-cycle, update the scoreboard, advance.
  task automatic tick();
    logic [MSG_W-1:0] exp;
    if (auto_cmp) uc_req_complete_i = sent_prev;
    @(negedge clk_i);
    last_yumi = (cache_req_yumi_o === 1'b1);
    last_v    = (lce_req_v_o === 1'b1);
    if (last_yumi) begin
      sb.push_back(model(cache_req_i, exp_way));
      yumi_q.push_back(cyc);
    end
    if (last_v) begin
      send_q.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_msg got %h expected none", lce_req_o);
      end else begin
        exp = sb.pop_front();
        if (lce_req_o !== exp) begin
          errors++;
          $display("FAIL msg_content got %h expected %h", lce_req_o, exp);
        end
      end
    end
    sent_prev = last_v;
    @(posedge clk_i);
    #1;
    cyc++;
    cache_req_metadata_v_i = 1'b0;
    cache_req_complete_i   = 1'b0;
    uc_req_complete_i      = 1'b0;
  endtask

  task automatic send_req(input logic [REQ_W-1:0] r);
    bit got;
    got = 1'b0;
    cache_req_i = r;
    cache_req_v_i = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = last_yumi;
    end
    cache_req_v_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout req %h not consumed", r);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (k < 50 && !(sb.size() == 0 && empty_o === 1'b1 && credits_empty_o === 1'b1)) begin
      tick();
      k++;
    end
    checks++;
    if (k >= 50) begin
      errors++;
      $display("FAIL drain_timeout pending %0d empty %b credits_empty %b required 0 1 1",
               sb.size(), empty_o, credits_empty_o);
    end
  endtask

  task automatic clear_logs();
    yumi_q.delete();
    send_q.delete();
  endtask

  task automatic test_reset();
    checks++; if (cache_req_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b expected 0", cache_req_yumi_o); end
    checks++; if (lce_req_v_o !== 1'b0) begin errors++; $display("FAIL reset_v got %b expected 0", lce_req_v_o); end
    checks++; if (lce_req_o !== '0) begin errors++; $display("FAIL reset_msg got %h expected 0", lce_req_o); end
    checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL reset_credits_empty got %b expected 1", credits_empty_o); end
    checks++; if (credits_full_o !== 1'b0) begin errors++; $display("FAIL reset_credits_full got %b expected 0", credits_full_o); end
    checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", empty_o); end
  endtask

  task automatic test_uc_store_b2b();
    int c0;
    auto_cmp = 1'b1; lce_req_ready_i = 1'b1;
    clear_logs();
    c0 = cyc;
    send_req(mk_req(4'd3, 40'h0000_1000, 3'd3, 64'h1111_2222_3333_4444, 1'b0));
    send_req(mk_req(4'd3, 40'h0000_1048, 3'd2, 64'h0000_0000_5555_6666, 1'b0));
    send_req(mk_req(4'd3, 40'h0000_10c0, 3'd3, 64'h7777_8888_9999_aaaa, 1'b0));
    drain();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (yumi_q.size() <= i || yumi_q[i] != c0 + i) begin
        errors++;
        $display("FAIL b2b_yumi_cycle[%0d] got %0d expected %0d", i,
                 (yumi_q.size() > i) ? yumi_q[i] - c0 : -1, i);
      end
      checks++;
      if (send_q.size() <= i || send_q[i] != c0 + i + 1) begin
        errors++;
        $display("FAIL b2b_send_cycle[%0d] got %0d expected %0d", i,
                 (send_q.size() > i) ? send_q[i] - c0 : -1, i + 1);
      end
    end
  endtask

  task automatic test_miss_load_meta();
    int c0;
    clear_logs();
    exp_way = 3'd5;
    c0 = cyc;
    send_req(mk_req(4'd0, 40'h0001_2340, 3'd0, 64'h0, 1'b0));
    tick();
    tick();
    cache_req_metadata_i = 3'd5; cache_req_metadata_v_i = 1'b1;
    tick();
    drain();
    checks++;
    if (send_q.size() != 1 || send_q[0] != c0 + 4) begin
      errors++;
      $display("FAIL miss_load_latency got sends %0d first %0d expected 1 at %0d",
               send_q.size(), (send_q.size() > 0) ? send_q[0] - c0 : -1, 4);
    end
  endtask

  task automatic test_amo();
    int c0;
    clear_logs();
    exp_way = 3'd2;
    c0 = cyc;
    send_req(mk_req(4'd7, 40'h0000_0080, 3'd3, 64'h1234, 1'b1));
    tick();
    cache_req_metadata_i = 3'd2; cache_req_metadata_v_i = 1'b1;
    tick();
    drain();
    checks++;
    if (send_q.size() != 1 || send_q[0] != c0 + 3) begin
      errors++;
      $display("FAIL amo_add_latency got sends %0d first %0d expected 1 at %0d",
               send_q.size(), (send_q.size() > 0) ? send_q[0] - c0 : -1, 3);
    end
    // metadata coincident with accept
    clear_logs();
    exp_way = 3'd6;
    c0 = cyc;
    cache_req_metadata_i = 3'd6; cache_req_metadata_v_i = 1'b1;
    send_req(mk_req(4'd6, 40'h0000_01c0, 3'd2, 64'hcafe_f00d, 1'b0));
    drain();
    checks++;
    if (send_q.size() != 1 || send_q[0] != c0 + 1) begin
      errors++;
      $display("FAIL amo_coincident_meta got sends %0d first %0d expected 1 at %0d",
               send_q.size(), (send_q.size() > 0) ? send_q[0] - c0 : -1, 1);
    end
  endtask

  task automatic test_credits();
    int ck;
    auto_cmp = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++)
      send_req(mk_req(4'd2, 40'h0000_2000 + 40'(i * 64), 3'd2, 64'h0, 1'b0));
    repeat (3) tick();
    checks++; if (send_q.size() != 2) begin errors++; $display("FAIL credit_limit_sends got %0d expected 2", send_q.size()); end
    checks++; if (credits_full_o !== 1'b1) begin errors++; $display("FAIL credit_full got %b expected 1", credits_full_o); end
    checks++; if (empty_o !== 1'b0) begin errors++; $display("FAIL credit_buffer_empty got %b expected 0", empty_o); end
    ck = cyc;
    cache_req_complete_i = 1'b1;
    tick();
    tick();
    checks++;
    if (send_q.size() != 3 || send_q[2] != ck + 1) begin
      errors++;
      $display("FAIL credit_release_send got sends %0d at %0d expected 3 at %0d",
               send_q.size(), (send_q.size() > 2) ? send_q[2] - ck : -1, 1);
    end
    cache_req_complete_i = 1'b1;
    tick();
    tick();
    cache_req_complete_i = 1'b1;
    tick();
    cache_req_complete_i = 1'b1;
    tick();
    checks++; if (send_q.size() != 4) begin errors++; $display("FAIL credit_all_sent got %0d expected 4", send_q.size()); end
    checks++; if (credits_empty_o !== 1'b1) begin errors++; $display("FAIL credit_drained got %b expected 1", credits_empty_o); end
    checks++; if (empty_o !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL credit_buffer_left got empty %b pending %0d expected 1 0", empty_o, sb.size()); end
    auto_cmp = 1'b1;
  endtask

  task automatic test_uncached_mode();
    clear_logs();
    lce_mode_i = 2'd0; sync_done_i = 1'b0;
    cache_req_i = mk_req(4'd1, 40'h0000_3000, 3'd3, 64'h0, 1'b0);
    cache_req_v_i = 1'b1;
    repeat (6) tick();
    cache_req_v_i = 1'b0;
    checks++; if (yumi_q.size() != 0) begin errors++; $display("FAIL uncached_miss_yumi got %0d expected 0", yumi_q.size()); end
    checks++; if (send_q.size() != 0 || empty_o !== 1'b1) begin errors++; $display("FAIL uncached_miss_issue got sends %0d empty %b expected 0 1", send_q.size(), empty_o); end
    send_req(mk_req(4'd2, 40'h0000_3040, 3'd1, 64'h0, 1'b0));
    drain();
    checks++; if (send_q.size() != 1) begin errors++; $display("FAIL uncached_uc_load got sends %0d expected 1", send_q.size()); end
    lce_mode_i = 2'd1; sync_done_i = 1'b1;
    cache_req_i = mk_req(4'd15, 40'h0000_3080, 3'd3, 64'h0, 1'b0);
    cache_req_v_i = 1'b1;
    repeat (4) tick();
    cache_req_v_i = 1'b0;
    checks++; if (yumi_q.size() != 1) begin errors++; $display("FAIL unknown_type_yumi got %0d expected 1", yumi_q.size()); end
  endtask

  task automatic test_reset_mid();
    auto_cmp = 1'b0; lce_req_ready_i = 1'b0;
    clear_logs();
    for (int i = 0; i < 4; i++)
      send_req(mk_req(4'd3, 40'h0000_4000 + 40'(i * 64), 3'd3, 64'(i + 100), 1'b0));
    cache_req_i = mk_req(4'd3, 40'h0000_4100, 3'd3, 64'd200, 1'b0);
    cache_req_v_i = 1'b1;
    tick();
    checks++; if (last_yumi || last_v) begin errors++; $display("FAIL full_blocked got yumi %b v %b expected 0 0", last_yumi, last_v); end
    lce_req_ready_i = 1'b1;
    tick();
    checks++; if (!(last_yumi && last_v)) begin errors++; $display("FAIL full_accept_pop got yumi %b v %b expected 1 1", last_yumi, last_v); end
    cache_req_i = mk_req(4'd3, 40'h0000_4140, 3'd3, 64'd300, 1'b0);
    #2;
    checks++; if (lce_req_v_o !== 1'b1 || cache_req_yumi_o !== 1'b1) begin errors++; $display("FAIL prereset_active got v %b yumi %b expected 1 1", lce_req_v_o, cache_req_yumi_o); end
    reset_i = 1'b1;
    #1;
    checks++; if (lce_req_v_o !== 1'b0 || cache_req_yumi_o !== 1'b0) begin errors++; $display("FAIL midreset_outputs got v %b yumi %b expected 0 0", lce_req_v_o, cache_req_yumi_o); end
    checks++; if (lce_req_o !== '0) begin errors++; $display("FAIL midreset_msg got %h expected 0", lce_req_o); end
    checks++; if (empty_o !== 1'b1 || credits_empty_o !== 1'b1 || credits_full_o !== 1'b0) begin errors++; $display("FAIL midreset_status got empty %b cempty %b cfull %b expected 1 1 0", empty_o, credits_empty_o, credits_full_o); end
    @(posedge clk_i);
    #1;
    cyc++;
    reset_i = 1'b0;
    cache_req_v_i = 1'b0;
    sb.delete();
    sent_prev = 1'b0;
    auto_cmp = 1'b1;
    clear_logs();
    send_req(mk_req(4'd3, 40'h0000_5000, 3'd3, 64'hbeef, 1'b0));
    drain();
    checks++; if (send_q.size() != 1 || yumi_q.size() != 1) begin errors++; $display("FAIL postreset_traffic got sends %0d accepts %0d expected 1 1", send_q.size(), yumi_q.size()); end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    auto_cmp = 1'b0; sent_prev = 1'b0; last_yumi = 1'b0; last_v = 1'b0; exp_way = 3'd0;
    reset_i = 1'b1;
    lce_id_i = LCE_ID; lce_mode_i = 2'd1; sync_done_i = 1'b1;
    cache_req_i = '0; cache_req_v_i = 1'b0;
    cache_req_metadata_i = 3'd0; cache_req_metadata_v_i = 1'b0;
    cache_req_complete_i = 1'b0; uc_req_complete_i = 1'b0;
    lce_req_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    test_reset();
    test_uc_store_b2b();
    test_miss_load_meta();
    test_amo();
    test_credits();
    test_uncached_mode();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time limit");
    $fatal(1);
  end

endmodule
